// File: rtl/seq_subtractor64_5.sv
// Multi-cycle 64-bit minus 5-bit subtractor: one SLICE_W-bit slice per clock,
// borrow rippled between slices, result presented on a valid/ready handshake.
module seq_subtractor64_5 #(
    parameter int SLICE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] A,
    input  logic [4:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:0] Diff,
    output logic        busy
);

    localparam int NSLICE = 64 / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [63:0]        r_a;
    logic [63:0]        r_b;
    logic [63:0]        r_res;
    logic               r_borrow;
    logic [IDX_W-1:0]   r_idx;
    logic [64:0]        r_diff;

    logic [5:0]         w_base;
    logic [SLICE_W-1:0] w_aSlice;
    logic [SLICE_W-1:0] w_bSlice;
    logic [SLICE_W:0]   w_sliceFull;
    logic               w_borrowNext;
    logic [63:0]        w_resNext;
    logic               w_lastSlice;

    assign w_base       = 6'(r_idx * SLICE_W);
    assign w_aSlice     = r_a[w_base +: SLICE_W];
    assign w_bSlice     = r_b[w_base +: SLICE_W];
    // The extra top bit of the widened difference is the borrow out of this slice.
    assign w_sliceFull  = {1'b0, w_aSlice} - {1'b0, w_bSlice} - {{SLICE_W{1'b0}}, r_borrow};
    assign w_borrowNext = w_sliceFull[SLICE_W];
    assign w_lastSlice  = (r_idx == LAST_IDX);
    assign Diff         = r_diff;

    always_comb begin
        w_resNext = r_res;
        w_resNext[w_base +: SLICE_W] = w_sliceFull[SLICE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastSlice) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Partial slices accumulate in r_res; Diff only changes once the last slice lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_diff   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= A;
                        r_b      <= {59'b0, B};
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_idx    <= '0;
                    end
                end
                RUN: begin
                    r_res    <= w_resNext;
                    r_borrow <= w_borrowNext;
                    r_idx    <= r_idx + 1'b1;
                    if (w_lastSlice) begin
                        r_diff <= {w_borrowNext, w_resNext};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_subtractor64_5.sv
// Scoreboarded bench for seq_subtractor64_5: three instances (SLICE_W 8, 1, 64),
// directed corner cases on the SLICE_W=8 lane, then random streaming on all lanes.
module tb_seq_subtractor64_5;

    localparam int NL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NL-1:0]        inValid;
    logic [NL-1:0]        inReady;
    logic [NL-1:0]        outValid;
    logic [NL-1:0]        outReady;
    logic [NL-1:0]        busy;
    logic [NL-1:0][63:0]  aIn;
    logic [NL-1:0][4:0]   bIn;
    logic [NL-1:0][64:0]  diff;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    typedef struct {
        logic [64:0] exp;
        int          accEdge;
    } item_t;

    item_t       sbQ [NL][$];
    logic [64:0] heldDiff [NL];
    logic        prevValid [NL];

    genvar g;
    generate
        for (g = 0; g < NL; g++) begin : lane
            seq_subtractor64_5 #(.SLICE_W(g == 0 ? 8 : (g == 1 ? 1 : 64))) dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (inValid[g]),
                .in_ready  (inReady[g]),
                .A         (aIn[g]),
                .B         (bIn[g]),
                .out_valid (outValid[g]),
                .out_ready (outReady[g]),
                .Diff      (diff[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    function automatic int laneSw(int l);
        return (l == 0) ? 8 : ((l == 1) ? 1 : 64);
    endfunction

    function automatic int laneNslice(int l);
        return 64 / laneSw(l);
    endfunction

    // Reference: 65-bit wraparound subtraction leaves the borrow in bit 64.
    function automatic logic [64:0] refDiff(logic [63:0] a, logic [4:0] b);
        return {1'b0, a} - {60'b0, b};
    endfunction

    function automatic void check(string name, int l, logic [64:0] act, logic [64:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s lane%0d (SLICE_W=%0d): got %h, expected %h",
                     name, l, laneSw(l), act, exp);
        end
    endfunction

    function automatic void checkBit(string name, int l, logic act, logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s lane%0d (SLICE_W=%0d): got %b, expected %b",
                     name, l, laneSw(l), act, exp);
        end
    endfunction

    function automatic logic [63:0] randA();
        case ($urandom_range(0, 3))
            0:       return 64'($urandom_range(0, 40));
            1:       return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    always @(posedge clk) cycle++;

    // Monitor: learns accepts from the handshake, checks latency, result and hold behaviour.
    always @(negedge clk) begin
        item_t it;
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                sbQ[l].delete();
                heldDiff[l]  = '0;
                prevValid[l] = 1'b0;
            end else begin
                if (outValid[l] && !prevValid[l]) begin
                    if (sbQ[l].size() == 0) begin
                        checkBit("spurious_out_valid", l, outValid[l], 1'b0);
                    end else begin
                        check("latency", l, 65'(cycle - sbQ[l][0].accEdge), 65'(laneNslice(l)));
                    end
                end
                if (!outValid[l]) begin
                    check("diff_held", l, diff[l], heldDiff[l]);
                end else if (outReady[l] && sbQ[l].size() > 0) begin
                    it = sbQ[l].pop_front();
                    check("diff", l, diff[l], it.exp);
                    heldDiff[l] = it.exp;
                end
                if (inValid[l] && inReady[l]) begin
                    it.exp     = refDiff(aIn[l], bIn[l]);
                    it.accEdge = cycle + 1;
                    sbQ[l].push_back(it);
                end
                prevValid[l] = outValid[l];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(int l, logic [63:0] a, logic [4:0] b);
        int n = 0;
        while (!inReady[l] && n < 300) begin
            tick();
            n++;
        end
        checkBit("wait_in_ready", l, inReady[l], 1'b1);
        inValid[l] = 1'b1;
        aIn[l]     = a;
        bIn[l]     = b;
        tick();
        inValid[l] = 1'b0;
    endtask

    task automatic waitOutValid(int l);
        int n = 0;
        while (!outValid[l] && n < 300) begin
            tick();
            n++;
        end
        checkBit("wait_out_valid", l, outValid[l], 1'b1);
    endtask

    task automatic checkOutput(int l, string name, logic [64:0] exp);
        waitOutValid(l);
        check(name, l, diff[l], exp);
    endtask

    task automatic runDirected(string name, logic [63:0] a, logic [4:0] b, logic [64:0] exp);
        applyStimulus(0, a, b);
        checkOutput(0, name, exp);
        tick();
    endtask

    task automatic streamLane(int l, int nOps);
        int lastAcc = -1;
        int n;
        outReady[l] = 1'b1;
        aIn[l]      = randA();
        bIn[l]      = 5'($urandom);
        inValid[l]  = 1'b1;
        for (int k = 0; k < nOps; k++) begin
            n = 0;
            while (!inReady[l] && n < 300) begin
                tick();
                n++;
            end
            checkBit("stream_in_ready", l, inReady[l], 1'b1);
            if (lastAcc >= 0) begin
                check("throughput", l, 65'(cycle + 1 - lastAcc), 65'(laneNslice(l) + 2));
            end
            lastAcc = cycle + 1;
            tick();
            aIn[l] = randA();
            bIn[l] = 5'($urandom);
        end
        inValid[l] = 1'b0;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        inValid  = '0;
        outReady = '1;
        aIn      = '0;
        bIn      = '0;
        tick();
        tick();

        // An operand offered while reset is still high must be dropped.
        inValid[0] = 1'b1;
        aIn[0]     = 64'h55;
        bIn[0]     = 5'd3;
        tick();
        rst        = 1'b0;
        inValid[0] = 1'b0;
        for (int l = 0; l < NL; l++) begin
            checkBit("reset_in_ready", l, inReady[l], 1'b1);
            checkBit("reset_out_valid", l, outValid[l], 1'b0);
            checkBit("reset_busy", l, busy[l], 1'b0);
            check("reset_diff", l, diff[l], 65'h0);
        end
        tick();
        checkBit("rst_accept_busy", 0, busy[0], 1'b0);

        runDirected("basic",        64'h10,                  5'd5,  65'h0_0000_0000_0000_000B);
        runDirected("full_ripple",  64'h0,                   5'd1,  65'h1_FFFF_FFFF_FFFF_FFFF);
        runDirected("cross_slice",  64'h0000_0001_0000_0000, 5'h1F, 65'h0_0000_0000_FFFF_FFE1);
        runDirected("equal_zero",   64'h1F,                  5'h1F, 65'h0);

        // Backpressure: result must hold while new operands knock on the input.
        outReady[0] = 1'b0;
        applyStimulus(0, 64'h0000_0001_2345_6789, 5'd3);
        waitOutValid(0);
        for (int k = 0; k < 5; k++) begin
            inValid[0] = 1'b1;
            aIn[0]     = 64'hFFFF_0000_FFFF_0000;
            bIn[0]     = 5'd17;
            tick();
            checkBit("bp_out_valid", 0, outValid[0], 1'b1);
            check("bp_diff", 0, diff[0], 65'h0_0000_0001_2345_6786);
            checkBit("bp_in_ready", 0, inReady[0], 1'b0);
        end
        inValid[0]  = 1'b0;
        outReady[0] = 1'b1;
        tick();
        checkBit("bp_release_valid", 0, outValid[0], 1'b0);
        checkBit("bp_release_ready", 0, inReady[0], 1'b1);
        check("bp_release_diff", 0, diff[0], 65'h0_0000_0001_2345_6786);

        // Reset on the third RUN edge abandons the operation.
        applyStimulus(0, 64'hDEAD_BEEF_0000_0001, 5'd3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkBit("midrst_out_valid", 0, outValid[0], 1'b0);
        checkBit("midrst_busy", 0, busy[0], 1'b0);
        checkBit("midrst_in_ready", 0, inReady[0], 1'b1);
        check("midrst_diff", 0, diff[0], 65'h0);
        runDirected("after_reset", 64'd7, 5'd2, 65'd5);

        fork
            streamLane(0, 100);
            streamLane(1, 100);
            streamLane(2, 100);
        join

        n = 0;
        while ((busy != '0) && n < 300) begin
            tick();
            n++;
        end
        checkBit("drain", 0, (busy == '0), 1'b1);
        for (int l = 0; l < NL; l++) begin
            check("scoreboard_empty", l, 65'(sbQ[l].size()), 65'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
